// File: rtl/rgb565_byte_assembler_if.sv
// rgb565_byte_assembler_if: camera byte stream and RGB565 video stream bundles.
interface byte_axis_if;
  logic [7:0] S_AXIS_TDATA;
  logic       S_AXIS_TVALID;
  logic       S_AXIS_TUSER;
  logic       S_AXIS_TREADY;
  modport master (output S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TUSER, input S_AXIS_TREADY);
  modport slave  (input S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TUSER, output S_AXIS_TREADY);
endinterface

interface video_axis_if;
  logic [15:0] M_AXIS_VIDEO_TDATA;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_VIDEO_TLAST;
  logic        M_AXIS_VIDEO_TUSER;
  logic        M_AXIS_VIDEO_TREADY;
  modport master (output M_AXIS_VIDEO_TDATA, M_AXIS_TVALID, M_AXIS_VIDEO_TLAST, M_AXIS_VIDEO_TUSER,
                  input M_AXIS_VIDEO_TREADY);
  modport slave  (input M_AXIS_VIDEO_TDATA, M_AXIS_TVALID, M_AXIS_VIDEO_TLAST, M_AXIS_VIDEO_TUSER,
                  output M_AXIS_VIDEO_TREADY);
endinterface

// File: rtl/rgb565_byte_assembler.sv
// rgb565_byte_assembler: pairs camera bytes into RGB565 pixels with SoF/EoL sideband.
module rgb565_byte_assembler #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         S_AXIS_ACLK,
  input  logic         s_axis_aresetn,
  byte_axis_if.slave   s_axis,
  video_axis_if.master m_axis,
  output logic         o_frame_err,
  output logic [15:0]  o_frame_count
);
  localparam int CW = H_ACTIVE > 1 ? $clog2(H_ACTIVE) : 1;
  localparam int RW = V_ACTIVE > 1 ? $clog2(V_ACTIVE) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(H_ACTIVE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(V_ACTIVE - 1);

  typedef enum logic [1:0] {WAIT_SOF, BYTE0, BYTE1} state_e;

  state_e        state_q, state_d;
  logic [7:0]    first_q, first_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [15:0]   tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d;
  logic          tlast_q, tlast_d;
  logic          tuser_q, tuser_d;
  logic          err_q, err_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          tready, beat, sof, last_col, last_row;

  // BYTE1 may only accept when the single output slot is free or draining
  assign tready   = s_axis_aresetn && (state_q != BYTE1 || !tvalid_q || m_axis.M_AXIS_VIDEO_TREADY);
  assign beat     = s_axis.S_AXIS_TVALID && tready;
  assign sof      = s_axis.S_AXIS_TUSER;
  assign last_col = col_q == COL_LAST;
  assign last_row = row_q == ROW_LAST;

  always_comb begin
    state_d  = state_q;
    first_d  = first_q;
    col_d    = col_q;
    row_d    = row_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    cnt_d    = cnt_q;
    tvalid_d = tvalid_q && !m_axis.M_AXIS_VIDEO_TREADY;
    err_d    = beat && sof && state_q != WAIT_SOF;
    if (beat && sof) begin
      first_d = s_axis.S_AXIS_TDATA;
      col_d   = '0;
      row_d   = '0;
      state_d = BYTE1;
    end else if (beat && state_q == BYTE0) begin
      first_d = s_axis.S_AXIS_TDATA;
      state_d = BYTE1;
    end else if (beat && state_q == BYTE1) begin
      tdata_d  = MSB_FIRST ? {first_q, s_axis.S_AXIS_TDATA} : {s_axis.S_AXIS_TDATA, first_q};
      tvalid_d = 1'b1;
      tuser_d  = col_q == '0 && row_q == '0;
      tlast_d  = last_col;
      col_d    = last_col ? '0 : col_q + 1'b1;
      row_d    = !last_col ? row_q : last_row ? '0 : row_q + 1'b1;
      cnt_d    = cnt_q + 16'(last_col && last_row);
      state_d  = last_col && last_row ? WAIT_SOF : BYTE0;
    end
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (!s_axis_aresetn) begin
      state_q  <= WAIT_SOF;
      first_q  <= '0;
      col_q    <= '0;
      row_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      first_q  <= first_d;
      col_q    <= col_d;
      row_q    <= row_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign s_axis.S_AXIS_TREADY      = tready;
  assign m_axis.M_AXIS_VIDEO_TDATA = tdata_q;
  assign m_axis.M_AXIS_TVALID      = tvalid_q;
  assign m_axis.M_AXIS_VIDEO_TLAST = tlast_q;
  assign m_axis.M_AXIS_VIDEO_TUSER = tuser_q;
  assign o_frame_err               = err_q;
  assign o_frame_count             = cnt_q;
endmodule

// File: tb/tb_rgb565_byte_assembler.sv
// tb_rgb565_byte_assembler: random and directed byte streams checked against a pixel-index frame model.
module tb_rgb565_byte_assembler;
  localparam int H = 4;
  localparam int V = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  byte_axis_if  b0 ();
  byte_axis_if  b1 ();
  video_axis_if v0 ();
  video_axis_if v1 ();
  logic        err0, err1;
  logic [15:0] cnt0, cnt1;

  assign b1.S_AXIS_TDATA        = b0.S_AXIS_TDATA;
  assign b1.S_AXIS_TVALID       = b0.S_AXIS_TVALID;
  assign b1.S_AXIS_TUSER        = b0.S_AXIS_TUSER;
  assign v1.M_AXIS_VIDEO_TREADY = v0.M_AXIS_VIDEO_TREADY;

  rgb565_byte_assembler #(.H_ACTIVE(H), .V_ACTIVE(V), .MSB_FIRST(1'b1)) dut_msb (
    .S_AXIS_ACLK(clk), .s_axis_aresetn(rstn), .s_axis(b0.slave), .m_axis(v0.master),
    .o_frame_err(err0), .o_frame_count(cnt0));
  rgb565_byte_assembler #(.H_ACTIVE(H), .V_ACTIVE(V), .MSB_FIRST(1'b0)) dut_lsb (
    .S_AXIS_ACLK(clk), .s_axis_aresetn(rstn), .s_axis(b1.slave), .m_axis(v1.master),
    .o_frame_err(err1), .o_frame_count(cnt1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {logic [7:0] a; logic [7:0] b; logic u; logic l;} pix_t;
  pix_t        q[$];
  bit          in_frame, has_first, err_exp, armed, rst_prev;
  logic [7:0]  first;
  int          pix;
  logic [15:0] frames = '0;
  logic [15:0] log0[$], log1[$];
  int          err_pulses = 0;
  bit          rand_mready = 0;
  bit          bp_arm = 0;
  int          bp_cnt = 0;

  // Model: bytes after SoF pair up; pixel index within the frame decides SoF/EoL.
  always @(negedge clk) begin
    bit exp_tr, beat, hs;
    exp_tr = rstn && (!has_first || q.size() == 0 || v0.M_AXIS_VIDEO_TREADY);
    if (armed) begin
      chk("s_tready", b0.S_AXIS_TREADY, exp_tr);
      chk("s_tready_lsb", b1.S_AXIS_TREADY, exp_tr);
      chk("m_tvalid", v0.M_AXIS_TVALID, q.size() > 0);
      chk("m_tvalid_lsb", v1.M_AXIS_TVALID, q.size() > 0);
      if (q.size() > 0) begin
        chk("m_tdata", v0.M_AXIS_VIDEO_TDATA, {q[0].a, q[0].b});
        chk("m_tdata_lsb", v1.M_AXIS_VIDEO_TDATA, {q[0].b, q[0].a});
        chk("m_tuser", {v1.M_AXIS_VIDEO_TUSER, v0.M_AXIS_VIDEO_TUSER}, {q[0].u, q[0].u});
        chk("m_tlast", {v1.M_AXIS_VIDEO_TLAST, v0.M_AXIS_VIDEO_TLAST}, {q[0].l, q[0].l});
      end else if (rst_prev) begin
        chk("rst_outs", {v0.M_AXIS_VIDEO_TDATA, v0.M_AXIS_VIDEO_TUSER, v0.M_AXIS_VIDEO_TLAST}, 0);
        chk("rst_outs_lsb", {v1.M_AXIS_VIDEO_TDATA, v1.M_AXIS_VIDEO_TUSER, v1.M_AXIS_VIDEO_TLAST}, 0);
      end
      chk("frame_err", {err1, err0}, {err_exp, err_exp});
      chk("frame_count", cnt0, frames);
      chk("frame_count_lsb", cnt1, frames);
    end
    if (err0) err_pulses++;
    if (v0.M_AXIS_TVALID && v0.M_AXIS_VIDEO_TREADY) begin
      log0.push_back(v0.M_AXIS_VIDEO_TDATA);
      log1.push_back(v1.M_AXIS_VIDEO_TDATA);
    end
    if (bp_arm && log0.size() == 2) begin
      bp_arm = 0;
      bp_cnt = 10;
    end
    hs      = q.size() > 0 && v0.M_AXIS_VIDEO_TREADY;
    beat    = b0.S_AXIS_TVALID && exp_tr;
    err_exp = 0;
    if (!rstn) begin
      q.delete();
      in_frame  = 0;
      has_first = 0;
      pix       = 0;
      frames    = '0;
      armed     = 1;
    end else begin
      if (hs) void'(q.pop_front());
      if (beat && b0.S_AXIS_TUSER) begin
        err_exp   = in_frame;
        in_frame  = 1;
        has_first = 1;
        first     = b0.S_AXIS_TDATA;
        pix       = 0;
      end else if (beat && in_frame && !has_first) begin
        first     = b0.S_AXIS_TDATA;
        has_first = 1;
      end else if (beat && in_frame) begin
        q.push_back(pix_t'({first, b0.S_AXIS_TDATA, pix == 0, pix % H == H - 1}));
        pix++;
        has_first = 0;
        if (pix == H * V) begin
          in_frame = 0;
          frames   = frames + 16'd1;
        end
      end
    end
    rst_prev = !rstn;
  end

  initial begin
    v0.M_AXIS_VIDEO_TREADY = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_cnt > 0) begin
        v0.M_AXIS_VIDEO_TREADY = 1'b0;
        bp_cnt--;
      end else v0.M_AXIS_VIDEO_TREADY = rand_mready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input logic [7:0] d, input logic u);
    bit acc;
    int n = 0;
    b0.S_AXIS_TDATA  = d;
    b0.S_AXIS_TUSER  = u;
    b0.S_AXIS_TVALID = 1'b1;
    do begin
      @(negedge clk);
      acc = b0.S_AXIS_TREADY;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout byte %h not accepted in %0d cycles", d, n);
    end
    b0.S_AXIS_TVALID = 1'b0;
    b0.S_AXIS_TUSER  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base);
    for (int i = 0; i < 2 * H * V; i++) send(base + 8'(i), i == 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    b0.S_AXIS_TDATA  = '0;
    b0.S_AXIS_TVALID = 1'b0;
    b0.S_AXIS_TUSER  = 1'b0;
    idle(3);
    chk("reset_tready", b0.S_AXIS_TREADY, 0);
    chk("reset_count", cnt0, 0);
    rstn = 1'b1;
    #1;
    chk("post_reset_tready", b0.S_AXIS_TREADY, 1);

    for (int i = 0; i < 5; i++) send(8'hF0 + 8'(i), 1'b0);
    send_frame(8'h00);
    idle(4);
    chk("dir_npix", log0.size(), 8);
    chk("dir_pix0", log0[0], 16'h0001);
    chk("dir_pix3", log0[3], 16'h0607);
    chk("dir_pix7", log0[7], 16'h0E0F);
    chk("dir_count", cnt0, 1);
    chk("dir_no_err", err_pulses, 0);

    log0.delete();
    log1.delete();
    bp_arm = 1;
    send_frame(8'h00);
    idle(4);
    chk("bp_npix", log0.size(), 8);
    chk("bp_pix2", log0[2], 16'h0405);
    chk("bp_pix3", log0[3], 16'h0607);
    chk("bp_count", cnt0, 2);

    log0.delete();
    log1.delete();
    for (int i = 0; i < 9; i++) send(8'(i), i == 0);
    send_frame(8'h00);
    idle(4);
    chk("short_err", err_pulses, 1);
    chk("short_npix", log0.size(), 12);
    chk("short_pix3", log0[3], 16'h0607);
    chk("short_pix4", log0[4], 16'h0001);
    chk("short_pix11", log0[11], 16'h0E0F);
    chk("short_count", cnt0, 3);

    log0.delete();
    log1.delete();
    send(8'hAA, 1'b1);
    send(8'h55, 1'b0);
    for (int i = 2; i < 2 * H * V; i++) send(8'(i), 1'b0);
    idle(4);
    chk("lsb_pix0", log1[0], 16'h55AA);
    chk("msb_pix0", log0[0], 16'hAA55);
    chk("lsb_count", cnt1, 4);

    for (int i = 0; i < 6; i++) send(8'h30 + 8'(i), i == 0);
    rstn = 1'b0;
    idle(2);
    chk("midrst_tready", b0.S_AXIS_TREADY, 0);
    chk("midrst_tvalid", v0.M_AXIS_TVALID, 0);
    rstn = 1'b1;
    log0.delete();
    log1.delete();
    err_pulses = 0;
    send_frame(8'h40);
    idle(4);
    chk("midrst_npix", log0.size(), 8);
    chk("midrst_pix0", log0[0], 16'h4041);
    chk("midrst_count", cnt0, 1);
    chk("midrst_no_err", err_pulses, 0);

    rand_mready = 1;
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) send(8'($urandom), 1'b0);
      for (int i = 0; i < 2 * H * V; i++) begin
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        send(8'($urandom), i == 0 || $urandom_range(0, 39) == 0);
      end
    end
    rand_mready = 0;
    idle(6);
    chk("rand_drained", v0.M_AXIS_TVALID, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
